vdp_port_ctrl: RTL and testbench
================================

Name: vdp_port_ctrl

Overview:
- Sequences all CPU-side access to the VDP on the SMS core: I/O ports $BE (data) and $BF (control/status).
- Decodes two-byte control writes into an address/code register, VDP register writes and CRAM writes.
- Schedules VRAM reads and writes toward the renderer's VRAM port over a req/ack handshake, with one-deep read-ahead and one pending slot.
- Owns the status flags and the interrupt line; sits between the bus decode (io_* strobes) and the video renderer.

Parameters:
- VADDR_W, 14, VRAM address width (16 KB).
- CRAM_AW, 5, CRAM address width (32 entries).

Ports:
- clk  in  1  system clock, 28.63636 MHz
- reset  in  1  asynchronous, active-high
- io_portsel  in  1  0 = data port, 1 = control/status port
- io_wrdata  in  8  CPU write data
- io_wren  in  1  1-cycle pulse at start of a CPU port write
- io_rddone  in  1  1-cycle pulse at end of a CPU port read (side effects commit here)
- io_rddata  out  8  combinational read data for the current io_portsel
- vram_req  out  1  VRAM access request, held until ack
- vram_we  out  1  1 = write, 0 = read; valid while vram_req
- vram_addr  out  VADDR_W  access address
- vram_wrdata  out  8  write data
- vram_ack  in  1  1-cycle pulse; on reads, vram_rddata is valid in the same cycle
- vram_rddata  in  8  VRAM read data
- cram_we  out  1  1-cycle CRAM write strobe
- cram_addr  out  CRAM_AW  CRAM address
- cram_wrdata  out  8  CRAM write data
- reg_we  out  1  1-cycle VDP register write strobe
- reg_idx  out  4  register index
- reg_val  out  8  register value
- vblank_stb  in  1  renderer: start of vblank
- line_irq_stb  in  1  renderer: line counter underflow
- spr_ovf_stb  in  1  renderer: sprite overflow
- spr_coll_stb  in  1  renderer: sprite collision
- irq  out  1  active-high interrupt request

Behaviour:
- Reset values: all outputs 0; address 0; code 0; first-byte flag 0; read buffer 0x00; all flags 0; ien_frame = ien_line = 0; FSM IDLE; pending slot empty.
- Control write, first byte (flag = 0): latch byte into addr[7:0]; set flag.
- Control write, second byte (flag = 1): addr[13:8] = data[5:0]; code = data[7:6]; clear flag. Then by code:
  - 0: queue prefetch read at addr; addr++.
  - 1: no access.
  - 2: reg_we pulses next cycle with reg_idx = data[3:0] and reg_val = first byte. Index 0 updates ien_line = value[4]; index 1 updates ien_frame = value[5].
- Data write (clears flag):
  - code 3: cram_we pulses next cycle, cram_addr = addr[4:0], cram_wrdata = data.
  - otherwise: queue a VRAM write at addr.
  - In both cases the read buffer is loaded with data; then addr++.
- Data read: io_rddata = read buffer. On io_rddone: clear flag, queue prefetch at addr, addr++.
- Status read: io_rddata = {vblank_flag, spr_ovf_flag, coll_flag, 5'b11111}. On io_rddone: clear flag, clear those three flags and line_pending.
- Address increment wraps 0x3FFF -> 0x0000.
- Flag set strobe coincident with status-read clear: set wins.
- irq = (vblank_flag & ien_frame) | (line_pending & ien_line); registered, 1-cycle latency from strobe.
- VRAM FSM:
  - IDLE -> BUSY when the pending slot is valid. Asserts vram_req/we/addr/wrdata from the slot and empties it.
  - BUSY -> IDLE on vram_ack. On a read ack, read buffer = vram_rddata.
  - Back-to-back ops: the queued op issues the cycle after ack.
- Pending slot holds one op. An op queued while the slot is full overwrites the slot (newest wins) and counts as an overrun. The in-flight op is never aborted.
- An io_wren coincident with a read ack: the CPU data-write buffer load wins over vram_rddata.
- Reset mid-access drops vram_req immediately; a late ack after reset is ignored.

Optional Feature:
- VDP_OVERRUN_CNT_EN.
- Defined: adds output dbg_overrun_cnt [7:0], a saturating count of pending-slot overwrites; reset 0, cleared by a reg_we to index 15.
- Undefined: the port still exists, tied to 8'h00; no counter logic.

Decomposition:
- Package vdp_pkg: code constants (CODE_VRD = 0, CODE_VWR = 1, CODE_REG = 2, CODE_CRAM = 3), FSM state enum, VADDR_W default, status bit positions.
- One sub-module, vdp_vram_sched: pending slot plus IDLE/BUSY FSM plus overrun detect. The top level keeps decode, address/code, flags and irq.

Test Plan:
- Write $BF 0x34, 0x52 (code 1): addr = 0x1234, no vram_req. Write $BE 0xAA: vram_req, we = 1, addr 0x1234, data 0xAA; ack -> next access uses addr 0x1235.
- Write $BF 0x05, 0x81: reg_we, idx 1, val 0x05; no VRAM access; flag cleared.
- Write $BF 0xFF, 0x3F (code 0): prefetch read at 0x3FFF; ack with 0x5A -> data read returns 0x5A and next prefetch addr = 0x0000 (wrap).
- Write $BF 0x03, 0xC0, then $BE 0x3F: cram_we, cram_addr 3, data 0x3F; no vram_req.
- Set ien_frame via reg1 = 0x20; pulse vblank_stb -> irq = 1 next cycle. Status read returns 0x9F, irq = 0 after io_rddone. vblank_stb coincident with io_rddone -> flag stays 1.
- Three data writes with ack withheld -> first in flight, slot holds third. With VDP_OVERRUN_CNT_EN defined, dbg_overrun_cnt = 1.

Source files
------------

// File: rtl/vdp_pkg.sv
// vdp_pkg: access codes, status bit positions, register indices and FSM state for the VDP CPU port
package vdp_pkg;
    localparam int DEF_VADDR_W = 14;
    localparam int DEF_CRAM_AW = 5;
    localparam logic [1:0] CODE_VRD = 2'd0;
    localparam logic [1:0] CODE_VWR = 2'd1;
    localparam logic [1:0] CODE_REG = 2'd2;
    localparam logic [1:0] CODE_CRAM = 2'd3;
    localparam int ST_VBLANK = 7;
    localparam int ST_SPR_OVF = 6;
    localparam int ST_COLL = 5;
    localparam logic [7:0] ST_FILL = 8'h1F;
    localparam logic [3:0] REG_IEN_LINE = 4'd0;
    localparam logic [3:0] REG_IEN_FRAME = 4'd1;
    localparam logic [3:0] REG_CNT_CLR = 4'd15;
    typedef enum logic {VS_IDLE, VS_BUSY} vram_state_t;
endpackage

// File: rtl/vdp_vram_sched.sv
// vdp_vram_sched: one-op pending slot feeding an IDLE/BUSY req/ack VRAM engine
// VDP_OVERRUN_CNT_EN adds the overrun pulse output used by the debug counter.
module vdp_vram_sched
    import vdp_pkg::*;
#(
    parameter int VADDR_W = DEF_VADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               push_we,
    input  logic [VADDR_W-1:0] push_addr,
    input  logic [7:0]         push_data,
    input  logic               vram_ack,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_wrdata,
`ifdef VDP_OVERRUN_CNT_EN
    output logic               overrun,
`endif
    output logic               rd_ack
);
    vram_state_t state, state_nx;
    logic slot_v, slot_we, op_we, take;
    logic [VADDR_W-1:0] slot_addr, op_addr;
    logic [7:0] slot_data, op_data;

    assign take = state == VS_IDLE && slot_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= VS_IDLE;
        else state <= state_nx;
    end

    // an ack in the issue cycle completes the op without entering BUSY
    always_comb begin
        state_nx = (take && !vram_ack) ? VS_BUSY : (state == VS_BUSY && vram_ack) ? VS_IDLE : state;
    end

    always_comb begin
        vram_req = take || state == VS_BUSY;
        vram_we = take ? slot_we : op_we;
        vram_addr = take ? slot_addr : op_addr;
        vram_wrdata = take ? slot_data : op_data;
        rd_ack = vram_ack && vram_req && !vram_we;
`ifdef VDP_OVERRUN_CNT_EN
        overrun = push && slot_v && !take;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v <= 1'b0;
            slot_we <= 1'b0;
            slot_addr <= '0;
            slot_data <= '0;
            op_we <= 1'b0;
            op_addr <= '0;
            op_data <= '0;
        end else begin
            if (push) begin
                slot_v <= 1'b1;
                slot_we <= push_we;
                slot_addr <= push_addr;
                slot_data <= push_data;
            end else if (take) begin
                slot_v <= 1'b0;
            end
            if (take) begin
                op_we <= slot_we;
                op_addr <= slot_addr;
                op_data <= slot_data;
            end
        end
    end
endmodule

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: SMS VDP CPU port ($BE data, $BF control/status) decode, flags and irq
// VDP_OVERRUN_CNT_EN enables the saturating pending-slot overwrite counter on dbg_overrun_cnt.
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter int VADDR_W = DEF_VADDR_W,
    parameter int CRAM_AW = DEF_CRAM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_portsel,
    input  logic [7:0]         io_wrdata,
    input  logic               io_wren,
    input  logic               io_rddone,
    output logic [7:0]         io_rddata,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_wrdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rddata,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [7:0]         cram_wrdata,
    output logic               reg_we,
    output logic [3:0]         reg_idx,
    output logic [7:0]         reg_val,
    input  logic               vblank_stb,
    input  logic               line_irq_stb,
    input  logic               spr_ovf_stb,
    input  logic               spr_coll_stb,
    output logic               irq,
    output logic [7:0]         dbg_overrun_cnt
);
    logic ctl_wr, dat_wr, dat_rd, st_rd, ctl2, reg_hit, cram_hit, push, rd_ack, flag;
    logic [VADDR_W-1:0] addr, ctl_addr, push_addr;
    logic [1:0] code;
    logic [7:0] rbuf, status;
    logic vblank_flag, spr_ovf_flag, coll_flag, line_pending, ien_frame, ien_line;
    logic vblank_nx, spr_ovf_nx, coll_nx, line_nx, ien_frame_nx, ien_line_nx;
`ifdef VDP_OVERRUN_CNT_EN
    logic overrun;
`endif

    always_comb begin
        ctl_wr = io_wren && io_portsel;
        dat_wr = io_wren && !io_portsel;
        dat_rd = io_rddone && !io_portsel;
        st_rd = io_rddone && io_portsel;
        ctl2 = ctl_wr && flag;
        ctl_addr = {io_wrdata[VADDR_W-9:0], addr[7:0]};
        reg_hit = ctl2 && io_wrdata[7:6] == CODE_REG;
        cram_hit = dat_wr && code == CODE_CRAM;
        push = (ctl2 && io_wrdata[7:6] == CODE_VRD) || (dat_wr && !cram_hit) || dat_rd;
        push_addr = ctl2 ? ctl_addr : addr;
        // the register value is the first control byte, still held in addr[7:0]
        ien_line_nx = (reg_hit && io_wrdata[3:0] == REG_IEN_LINE) ? addr[4] : ien_line;
        ien_frame_nx = (reg_hit && io_wrdata[3:0] == REG_IEN_FRAME) ? addr[5] : ien_frame;
        vblank_nx = vblank_stb || (vblank_flag && !st_rd);
        spr_ovf_nx = spr_ovf_stb || (spr_ovf_flag && !st_rd);
        coll_nx = spr_coll_stb || (coll_flag && !st_rd);
        line_nx = line_irq_stb || (line_pending && !st_rd);
        status = ST_FILL;
        status[ST_VBLANK] = vblank_flag;
        status[ST_SPR_OVF] = spr_ovf_flag;
        status[ST_COLL] = coll_flag;
        io_rddata = io_portsel ? status : rbuf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            code <= CODE_VRD;
            flag <= 1'b0;
            rbuf <= 8'h00;
            vblank_flag <= 1'b0;
            spr_ovf_flag <= 1'b0;
            coll_flag <= 1'b0;
            line_pending <= 1'b0;
            ien_frame <= 1'b0;
            ien_line <= 1'b0;
            irq <= 1'b0;
            reg_we <= 1'b0;
            reg_idx <= '0;
            reg_val <= '0;
            cram_we <= 1'b0;
            cram_addr <= '0;
            cram_wrdata <= '0;
        end else begin
            if (ctl2) begin
                addr <= ctl_addr + VADDR_W'(io_wrdata[7:6] == CODE_VRD);
                code <= io_wrdata[7:6];
            end else if (ctl_wr) begin
                addr[7:0] <= io_wrdata;
            end else if (dat_wr || dat_rd) begin
                addr <= addr + VADDR_W'(1);
            end
            flag <= ctl_wr ? !flag : (io_wren || io_rddone) ? 1'b0 : flag;
            // a CPU data write beats a read ack landing in the same cycle
            rbuf <= dat_wr ? io_wrdata : rd_ack ? vram_rddata : rbuf;
            vblank_flag <= vblank_nx;
            spr_ovf_flag <= spr_ovf_nx;
            coll_flag <= coll_nx;
            line_pending <= line_nx;
            ien_frame <= ien_frame_nx;
            ien_line <= ien_line_nx;
            irq <= (vblank_nx && ien_frame_nx) || (line_nx && ien_line_nx);
            reg_we <= reg_hit;
            if (reg_hit) begin
                reg_idx <= io_wrdata[3:0];
                reg_val <= addr[7:0];
            end
            cram_we <= cram_hit;
            if (cram_hit) begin
                cram_addr <= addr[CRAM_AW-1:0];
                cram_wrdata <= io_wrdata;
            end
        end
    end

    vdp_vram_sched #(.VADDR_W(VADDR_W)) u_sched (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_we    (dat_wr),
        .push_addr  (push_addr),
        .push_data  (io_wrdata),
        .vram_ack   (vram_ack),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wrdata(vram_wrdata),
`ifdef VDP_OVERRUN_CNT_EN
        .overrun    (overrun),
`endif
        .rd_ack     (rd_ack)
    );

`ifdef VDP_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dbg_overrun_cnt <= 8'h00;
        else if (reg_we && reg_idx == REG_CNT_CLR) dbg_overrun_cnt <= 8'h00;
        else if (overrun && dbg_overrun_cnt != 8'hFF) dbg_overrun_cnt <= dbg_overrun_cnt + 8'd1;
    end
`else
    assign dbg_overrun_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_vdp_port_ctrl.sv
// tb_vdp_port_ctrl: directed self-checking bench for vdp_port_ctrl
module tb_vdp_port_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic io_portsel = 1'b0, io_wren = 1'b0, io_rddone = 1'b0;
    logic [7:0] io_wrdata = 8'h00, io_rddata;
    logic vram_req, vram_we, vram_ack = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0] vram_wrdata, vram_rddata = 8'h00;
    logic cram_we, reg_we, irq;
    logic [4:0] cram_addr;
    logic [7:0] cram_wrdata, reg_val, dbg_overrun_cnt;
    logic [3:0] reg_idx;
    logic vblank_stb = 1'b0, line_irq_stb = 1'b0, spr_ovf_stb = 1'b0, spr_coll_stb = 1'b0;
    int total = 0, passed = 0, fails = 0;

    vdp_port_ctrl dut (
        .clk(clk), .reset(reset),
        .io_portsel(io_portsel), .io_wrdata(io_wrdata), .io_wren(io_wren),
        .io_rddone(io_rddone), .io_rddata(io_rddata),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wrdata(vram_wrdata), .vram_ack(vram_ack), .vram_rddata(vram_rddata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wrdata(cram_wrdata),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_val(reg_val),
        .vblank_stb(vblank_stb), .line_irq_stb(line_irq_stb),
        .spr_ovf_stb(spr_ovf_stb), .spr_coll_stb(spr_coll_stb),
        .irq(irq), .dbg_overrun_cnt(dbg_overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic ps, input logic [7:0] d);
        io_portsel = ps;
        io_wrdata = d;
        io_wren = 1'b1;
        step();
        io_wren = 1'b0;
    endtask

    task automatic rd(input logic ps);
        io_portsel = ps;
        io_rddone = 1'b1;
        step();
        io_rddone = 1'b0;
    endtask

    task automatic ack_op(input logic [7:0] d);
        step();
        vram_rddata = d;
        vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
    endtask

    task automatic sel(input logic ps);
        io_portsel = ps;
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check("rst_req", vram_req, 0);
        check("rst_irq", irq, 0);
        check("rst_rbuf", io_rddata, 8'h00);
        check("rst_reg_we", reg_we, 0);
        check("rst_cram_we", cram_we, 0);
        check("rst_dbg", dbg_overrun_cnt, 0);
        reset = 1'b0;
        step();

        wr(1, 8'h34);
        wr(1, 8'h52);
        check("code1_no_req", vram_req, 0);
        wr(0, 8'hAA);
        check("vwr_req", vram_req, 1);
        check("vwr_we", vram_we, 1);
        check("vwr_addr", vram_addr, 14'h1234);
        check("vwr_data", vram_wrdata, 8'hAA);
        ack_op(8'h00);
        check("vwr_done", vram_req, 0);
        wr(0, 8'hBB);
        check("vwr2_addr", vram_addr, 14'h1235);
        check("vwr2_rbuf", io_rddata, 8'hBB);
        ack_op(8'h00);

        wr(1, 8'h05);
        wr(1, 8'h81);
        check("reg_we", reg_we, 1);
        check("reg_idx", reg_idx, 4'd1);
        check("reg_val", reg_val, 8'h05);
        check("reg_no_req", vram_req, 0);
        step();
        check("reg_we_pulse", reg_we, 0);

        wr(1, 8'hFF);
        wr(1, 8'h3F);
        check("pf_req", vram_req, 1);
        check("pf_we", vram_we, 0);
        check("pf_addr", vram_addr, 14'h3FFF);
        ack_op(8'h5A);
        sel(0);
        check("pf_rbuf", io_rddata, 8'h5A);
        rd(0);
        check("pf_wrap_addr", vram_addr, 14'h0000);
        check("pf_wrap_req", vram_req, 1);
        ack_op(8'h11);
        check("pf2_rbuf", io_rddata, 8'h11);

        wr(1, 8'h03);
        wr(1, 8'hC0);
        wr(0, 8'h3F);
        check("cram_we", cram_we, 1);
        check("cram_addr", cram_addr, 5'd3);
        check("cram_data", cram_wrdata, 8'h3F);
        check("cram_no_req", vram_req, 0);
        check("cram_rbuf", io_rddata, 8'h3F);

        wr(1, 8'h20);
        wr(1, 8'h81);
        step();
        vblank_stb = 1'b1;
        step();
        vblank_stb = 1'b0;
        check("vbl_irq", irq, 1);
        sel(1);
        check("vbl_status", io_rddata, 8'h9F);
        rd(1);
        check("vbl_irq_clr", irq, 0);
        check("vbl_status_clr", io_rddata, 8'h1F);
        vblank_stb = 1'b1;
        io_rddone = 1'b1;
        step();
        vblank_stb = 1'b0;
        io_rddone = 1'b0;
        check("set_wins_status", io_rddata, 8'h9F);
        check("set_wins_irq", irq, 1);
        rd(1);
        check("vbl_irq_clr2", irq, 0);

        wr(1, 8'h10);
        wr(1, 8'h80);
        line_irq_stb = 1'b1;
        step();
        line_irq_stb = 1'b0;
        check("line_irq", irq, 1);
        check("line_status", io_rddata, 8'h1F);
        rd(1);
        check("line_irq_clr", irq, 0);
        spr_ovf_stb = 1'b1;
        spr_coll_stb = 1'b1;
        step();
        spr_ovf_stb = 1'b0;
        spr_coll_stb = 1'b0;
        check("spr_status", io_rddata, 8'h7F);
        check("spr_no_irq", irq, 0);
        rd(1);
        check("spr_status_clr", io_rddata, 8'h1F);

        wr(1, 8'h00);
        wr(1, 8'h40);
        wr(0, 8'h01);
        wr(0, 8'h02);
        wr(0, 8'h03);
        check("ovr_inflight_addr", vram_addr, 14'h0000);
        check("ovr_inflight_data", vram_wrdata, 8'h01);
        vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
        check("ovr_next_req", vram_req, 1);
        check("ovr_next_addr", vram_addr, 14'h0002);
        check("ovr_next_data", vram_wrdata, 8'h03);
`ifdef VDP_OVERRUN_CNT_EN
        check("ovr_cnt", dbg_overrun_cnt, 8'd1);
`else
        check("ovr_cnt_tied", dbg_overrun_cnt, 8'd0);
`endif
        ack_op(8'h00);
        check("ovr_drained", vram_req, 0);
        wr(1, 8'h00);
        wr(1, 8'h8F);
        step();
        check("ovr_cnt_clr", dbg_overrun_cnt, 8'd0);

        wr(1, 8'h00);
        wr(1, 8'h00);
        step();
        vram_rddata = 8'h77;
        vram_ack = 1'b1;
        io_portsel = 1'b0;
        io_wrdata = 8'h66;
        io_wren = 1'b1;
        step();
        vram_ack = 1'b0;
        io_wren = 1'b0;
        check("wr_beats_ack", io_rddata, 8'h66);
        check("wr_after_ack_we", vram_we, 1);
        check("wr_after_ack_addr", vram_addr, 14'h0001);
        ack_op(8'h00);

        wr(1, 8'h00);
        wr(1, 8'h00);
        check("mid_req", vram_req, 1);
        reset = 1'b1;
        #1;
        check("rst_drops_req", vram_req, 0);
        step();
        reset = 1'b0;
        vram_rddata = 8'hEE;
        vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
        sel(0);
        check("late_ack_req", vram_req, 0);
        check("late_ack_rbuf", io_rddata, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
